// File: rtl/gpio_key_debounce.sv
// gpio_key_debounce: debounces N_KEYS raw key pins and publishes a single-entry key-event register.
//
// Ports:
//    clk          system clock
//    rst          synchronous reset, active-high
//    key_in       raw asynchronous key pins (pressed=1, or pressed=0 with KEY_ACTIVE_LOW_EN)
//    key_ack      consumer acknowledge of key_code, honoured only while key_valid=1
//    key_state    debounced level per key (pressed=1)
//    key_press    1-cycle strobe per key on debounced 0->1
//    key_release  1-cycle strobe per key on debounced 1->0
//    key_valid    key_code holds an unacknowledged press event
//    key_code     lowest index of the captured press
//    key_overrun  1-cycle strobe when a press is dropped because the register is full
//
// Build option: define KEY_ACTIVE_LOW_EN for pins that read 0 while pressed.
module gpio_key_debounce #(
   parameter int N_KEYS       = 8,
   parameter int TICK_DIV     = 100000,
   parameter int STABLE_TICKS = 20,
   localparam int CODE_W      = $clog2(N_KEYS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key_in,
   input  logic              key_ack,
   output logic [N_KEYS-1:0] key_state,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic              key_valid,
   output logic [CODE_W-1:0] key_code,
   output logic              key_overrun
);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   // The synchroniser sits on the pin itself and resets to the pin's idle level;
   // xor with the same constant maps the pin polarity to pressed=1.
`ifdef KEY_ACTIVE_LOW_EN
   localparam logic [N_KEYS-1:0] PIN_IDLE = '1;
`else
   localparam logic [N_KEYS-1:0] PIN_IDLE = '0;
`endif
   logic [N_KEYS-1:0]      ff1_q, ff2_q, sync_s;
   logic [TW-1:0]          tick_q, tick_d;
   logic                   tick_s;
   logic [N_KEYS-1:0][7:0] cnt_q, cnt_d;
   logic [N_KEYS-1:0]      state_q, state_d, prev_q, press_q, release_q;
   logic                   valid_q, valid_d, ovr_q, ovr_d, p_s;
   logic [CODE_W-1:0]      code_q, code_d, low_s;

   assign sync_s = ff2_q ^ PIN_IDLE;
   assign tick_s = tick_q == TW'(TICK_DIV - 1);
   assign tick_d = tick_s ? '0 : tick_q + 1'b1;
   assign p_s    = |press_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      for (int i = 0; i < N_KEYS; i++) begin
         if (tick_s) begin
            if (sync_s[i] == state_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == 8'(STABLE_TICKS - 1)) begin
               state_d[i] = sync_s[i];
               cnt_d[i]   = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + 8'd1;
            end
         end
      end
   end

   // Scan downwards so the lowest set index wins.
   always_comb begin
      low_s = '0;
      for (int i = N_KEYS - 1; i >= 0; i--)
         if (press_q[i]) low_s = CODE_W'(i);
   end

   always_comb begin
      valid_d = valid_q;
      code_d  = code_q;
      ovr_d   = 1'b0;
      if (p_s && (!valid_q || key_ack)) begin
         valid_d = 1'b1;
         code_d  = low_s;
      end else if (p_s) begin
         ovr_d = 1'b1;
      end else if (valid_q && key_ack) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ff1_q     <= PIN_IDLE;
         ff2_q     <= PIN_IDLE;
         tick_q    <= '0;
         cnt_q     <= '0;
         state_q   <= '0;
         prev_q    <= '0;
         press_q   <= '0;
         release_q <= '0;
         valid_q   <= 1'b0;
         code_q    <= '0;
         ovr_q     <= 1'b0;
      end else begin
         ff1_q     <= key_in;
         ff2_q     <= ff1_q;
         tick_q    <= tick_d;
         cnt_q     <= cnt_d;
         state_q   <= state_d;
         prev_q    <= state_q;
         press_q   <= state_q & ~prev_q;
         release_q <= ~state_q & prev_q;
         valid_q   <= valid_d;
         code_q    <= code_d;
         ovr_q     <= ovr_d;
      end
   end

   assign key_state   = state_q;
   assign key_press   = press_q;
   assign key_release = release_q;
   assign key_valid   = valid_q;
   assign key_code    = code_q;
   assign key_overrun = ovr_q;
endmodule

// File: tb/tb_gpio_key_debounce.sv
// tb_gpio_key_debounce: directed bench for gpio_key_debounce with TICK_DIV=4, STABLE_TICKS=3, N_KEYS=8.
module tb_gpio_key_debounce;
   localparam int N = 8;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] key_in;
   logic         key_ack = 1'b0;
   logic [N-1:0] key_state, key_press, key_release;
   logic         key_valid, key_overrun;
   logic [2:0]   key_code;
   int           total = 0;
   int           bad = 0;
   int           n;

   gpio_key_debounce #(.N_KEYS(N), .TICK_DIV(4), .STABLE_TICKS(3)) dut (
      .clk(clk), .rst(rst), .key_in(key_in), .key_ack(key_ack),
      .key_state(key_state), .key_press(key_press), .key_release(key_release),
      .key_valid(key_valid), .key_code(key_code), .key_overrun(key_overrun)
   );

   always #5 clk = ~clk;

   function automatic logic [N-1:0] pin(input logic [N-1:0] v);
`ifdef KEY_ACTIVE_LOW_EN
      return ~v;
`else
      return v;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic ack_pulse();
      key_ack = 1'b1;
      step();
      key_ack = 1'b0;
   endtask

   initial begin
      key_in = pin(8'h00);
      repeat (3) step();
      chk("rst_state", 32'(key_state), 0);
      chk("rst_press", 32'(key_press), 0);
      chk("rst_evt", {key_release, key_valid, key_code, key_overrun}, 0);
      rst = 1'b0;
      // 1: key 2 press, latency window, event capture
      key_in = pin(8'h04);
      for (n = 0; n < 40 && key_state[2] !== 1'b1; n++) step();
      chk("t1_latency_ok", 32'(n >= 11 && n <= 14), 1);
      chk("t1_state", 32'(key_state), 32'h04);
      step();
      chk("t1_press", 32'(key_press), 32'h04);
      chk("t1_valid_early", 32'(key_valid), 0);
      step();
      chk("t1_press_gone", 32'(key_press), 0);
      chk("t1_valid", 32'(key_valid), 1);
      chk("t1_code", 32'(key_code), 2);
      ack_pulse();
      chk("t1_ack", 32'(key_valid), 0);
      key_in = pin(8'h00);
      for (n = 0; n < 40 && key_state[2] !== 1'b0; n++) step();
      step();
      chk("t1_release", 32'(key_release), 32'h04);
      step();
      chk("t1_no_event", {key_release, key_valid}, 0);
      // 2: 6-cycle glitch on key 5 is rejected
      key_in = pin(8'h20);
      repeat (6) step();
      key_in = pin(8'h00);
      for (int i = 0; i < 20; i++) begin
         chk("t2_quiet", {key_state, key_press, 7'(key_valid)}, 0);
         step();
      end
      // 3: simultaneous press of keys 1 and 6
      key_in = pin(8'h42);
      for (n = 0; n < 40 && key_press === 8'h00; n++) step();
      chk("t3_press", 32'(key_press), 32'h42);
      step();
      chk("t3_valid", 32'(key_valid), 1);
      chk("t3_code", 32'(key_code), 1);
      ack_pulse();
      chk("t3_ack", 32'(key_valid), 0);
      key_in = pin(8'h00);
      for (n = 0; n < 40 && key_state !== 8'h00; n++) step();
      repeat (2) step();
      // 4: overrun, then press accepted alongside ack
      key_in = pin(8'h08);
      for (n = 0; n < 40 && key_press === 8'h00; n++) step();
      step();
      chk("t4_code3", {key_valid, 29'(key_code)}, {1'b1, 29'd3});
      key_in = pin(8'h88);
      for (n = 0; n < 40 && key_press === 8'h00; n++) step();
      chk("t4_press7", 32'(key_press), 32'h80);
      step();
      chk("t4_overrun", 32'(key_overrun), 1);
      chk("t4_code_kept", {key_valid, 29'(key_code)}, {1'b1, 29'd3});
      step();
      chk("t4_overrun_1cyc", 32'(key_overrun), 0);
      key_in = pin(8'h08);
      for (n = 0; n < 40 && key_state[7] !== 1'b0; n++) step();
      repeat (2) step();
      key_in = pin(8'h88);
      for (n = 0; n < 40 && key_press === 8'h00; n++) step();
      chk("t4_press7b", 32'(key_press), 32'h80);
      ack_pulse();
      chk("t4_ack_valid", 32'(key_valid), 1);
      chk("t4_ack_code", 32'(key_code), 7);
      chk("t4_ack_no_ovr", 32'(key_overrun), 0);
      ack_pulse();
      key_in = pin(8'h00);
      for (n = 0; n < 40 && key_state !== 8'h00; n++) step();
      repeat (2) step();
      // 5: key 0 press then release
      key_in = pin(8'h01);
      for (n = 0; n < 40 && key_state[0] !== 1'b1; n++) step();
      repeat (2) step();
      chk("t5_code", {key_valid, 29'(key_code)}, {1'b1, 29'd0});
      ack_pulse();
      key_in = pin(8'h00);
      for (n = 0; n < 40 && key_state[0] !== 1'b0; n++) step();
      chk("t5_rel_latency_ok", 32'(n <= 14), 1);
      step();
      chk("t5_release", 32'(key_release), 32'h01);
      step();
      chk("t5_release_1cyc", 32'(key_release), 0);
      chk("t5_no_event", 32'(key_valid), 0);
      // 6: reset while key 4 held and an event pending
      key_in = pin(8'h10);
      for (n = 0; n < 40 && key_press === 8'h00; n++) step();
      step();
      chk("t6_pre_valid", {key_valid, 29'(key_code)}, {1'b1, 29'd4});
      rst = 1'b1;
      step();
      chk("t6_rst_zero", {key_state, key_press, key_release, key_valid, key_code, key_overrun}, 0);
      step();
      chk("t6_rst_zero2", {key_state, key_press, key_release, key_valid, key_code, key_overrun}, 0);
      rst = 1'b0;
      for (n = 0; n < 40 && key_press[4] !== 1'b1; n++) step();
      chk("t6_repress_ok", 32'(n <= 15), 1);
      chk("t6_repress", 32'(key_press), 32'h10);
      step();
      chk("t6_code", {key_valid, 29'(key_code)}, {1'b1, 29'd4});
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
